red_pitaya_acq_ch: RTL and testbench

- Single-channel acquisition path: the receive-side counterpart of the ASG channel.
- Takes signed 14-bit ADC samples, decimates them (optionally averaging), and writes them into a circular BRAM buffer.
- Trigger FSM selects a trigger source, records the trigger position, counts a post-trigger sample delay, then stops writing.
- Bus side reads the buffer back and reads status/pointers.

---
 rtl/red_pitaya_acq_ch.sv | 240 ++++++++++++++++++++++++
 tb/tb_red_pitaya_acq_ch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_acq_ch.sv
// Single-channel acquisition path. Each ADC sample is registered, decimated
// (optionally averaged) and written into a circular buffer. A trigger FSM
// stops the capture a programmable number of decimated samples after the
// trigger. Buffer contents can be read back with a 1-cycle latency.
//
// Valid strobe: dec_valid_q is high for exactly one cycle per decimated
// sample, and dec_dat_q holds that sample in the same cycle. There is no
// back-pressure. Both the buffer write and the level trigger consume the
// sample in the cycle where dec_valid_q is high.
module red_pitaya_acq_ch #(
  parameter int RSZ = 14
) (
  input  logic           adc_clk_i,
  input  logic           adc_rstn_i,
  input  logic [13:0]    adc_dat_i,
  input  logic           trig_sw_i,
  input  logic           trig_ext_i,
  input  logic [2:0]     trig_src_i,
  input  logic           set_arm_i,
  input  logic           set_rst_i,
  input  logic [16:0]    set_dec_i,
  input  logic           set_avg_en_i,
  input  logic [13:0]    set_tresh_i,
  input  logic [13:0]    set_hyst_i,
  input  logic [31:0]    set_dly_i,
  input  logic [RSZ-1:0] buf_addr_i,
  output logic [13:0]    buf_rdata_o,
  output logic [RSZ-1:0] wpnt_o,
  output logic [RSZ-1:0] trig_pnt_o,
  output logic [1:0]     state_o,
  output logic           trig_o,
  output logic           done_o
);

  // The state encoding is the {triggered, armed} status word itself.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_TRIGD = 2'b11,
    ST_DONE  = 2'b10
  } state_t;

  localparam int DEPTH = 1 << RSZ;

  logic               clr;
  logic [13:0]        adc_q;
  logic [16:0]        dec_cnt_q, dec_len_q, eff_len, load_len;
  logic               win_end;
  logic [4:0]         dec_shift;
  logic signed [30:0] acc_q, acc_base, acc_sum, acc_shr;
  logic               dec_valid_q;
  logic [13:0]        dec_dat_q;

  logic               ext_ff1_q, ext_ff2_q, ext_prev_q;
  logic               prim_r_q, prim_f_q;
  logic signed [15:0] lvl_s, lvl_t, lvl_h, lvl_lo, lvl_hi;
  logic               lvl_rise, lvl_fall, trig_ev;

  state_t             state_q, state_d;
  logic [RSZ-1:0]     wpnt_q, wpnt_d, trig_pnt_q, trig_pnt_d;
  logic [31:0]        dly_q, dly_d;
  logic               trig_q, trig_d, we;
  logic [13:0]        buf_mem [0:DEPTH-1];
  logic [13:0]        rdata_q;

  assign clr = set_arm_i | set_rst_i;

  // Decimator window length, accumulator sum and averaging shift (floor(log2 D)).
  always_comb begin
    eff_len  = (dec_len_q == 17'd0) ? 17'd1 : dec_len_q;
    load_len = (set_dec_i == 17'd0) ? 17'd1 : set_dec_i;
    win_end  = (dec_cnt_q == eff_len - 17'd1);
    acc_base = (dec_cnt_q == 17'd0) ? 31'sd0 : acc_q;
    acc_sum  = acc_base + {{17{adc_q[13]}}, adc_q};
    dec_shift = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (eff_len[i]) dec_shift = 5'(i);
    end
    acc_shr = acc_sum >>> dec_shift;
  end

  // Input register and decimator/accumulator; a new length is picked up only at window boundaries.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      adc_q       <= '0;
      dec_cnt_q   <= '0;
      dec_len_q   <= '0;
      acc_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_dat_q   <= '0;
    end else begin
      adc_q <= adc_dat_i;
      if (clr) begin
        dec_cnt_q   <= '0;
        dec_len_q   <= load_len;
        acc_q       <= '0;
        dec_valid_q <= 1'b0;
      end else begin
        acc_q       <= acc_sum;
        dec_valid_q <= win_end;
        if (win_end) begin
          dec_cnt_q <= '0;
          dec_len_q <= load_len;
          dec_dat_q <= set_avg_en_i ? 14'(acc_shr) : adc_q;
        end else begin
          dec_cnt_q <= dec_cnt_q + 17'd1;
        end
      end
    end
  end

  // Level comparisons are done 16 bits wide so threshold +/- hysteresis cannot wrap.
  always_comb begin
    lvl_s    = {{2{dec_dat_q[13]}}, dec_dat_q};
    lvl_t    = {{2{set_tresh_i[13]}}, set_tresh_i};
    lvl_h    = {2'b00, set_hyst_i};
    lvl_lo   = lvl_t - lvl_h;
    lvl_hi   = lvl_t + lvl_h;
    lvl_rise = dec_valid_q && prim_r_q && (lvl_s >= lvl_t);
    lvl_fall = dec_valid_q && prim_f_q && (lvl_s <= lvl_t);
  end

  // External trigger synchronizer and edge history, plus level-trigger priming flags.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ext_ff1_q  <= 1'b0;
      ext_ff2_q  <= 1'b0;
      ext_prev_q <= 1'b0;
      prim_r_q   <= 1'b0;
      prim_f_q   <= 1'b0;
    end else begin
      ext_ff1_q  <= trig_ext_i;
      ext_ff2_q  <= ext_ff1_q;
      ext_prev_q <= ext_ff2_q;
      if (clr) begin
        prim_r_q <= 1'b0;
        prim_f_q <= 1'b0;
      end else if (dec_valid_q) begin
        if (lvl_rise)             prim_r_q <= 1'b0;
        else if (lvl_s < lvl_lo)  prim_r_q <= 1'b1;
        if (lvl_fall)             prim_f_q <= 1'b0;
        else if (lvl_s > lvl_hi)  prim_f_q <= 1'b1;
      end
    end
  end

  // Trigger source select.
  always_comb begin
    case (trig_src_i)
      3'd1:    trig_ev = trig_sw_i;
      3'd2:    trig_ev = lvl_rise;
      3'd3:    trig_ev = lvl_fall;
      3'd4:    trig_ev = ext_ff2_q & ~ext_prev_q;
      3'd5:    trig_ev = ~ext_ff2_q & ext_prev_q;
      default: trig_ev = 1'b0;
    endcase
  end

  // Next state, write enable and pointers. A trigger tags wpnt_q in both cases:
  // that address is either written this cycle or is the next one written.
  always_comb begin
    state_d    = state_q;
    wpnt_d     = wpnt_q;
    trig_pnt_d = trig_pnt_q;
    dly_d      = dly_q;
    trig_d     = 1'b0;
    we         = 1'b0;
    if (set_rst_i) begin
      state_d = ST_IDLE;
    end else if (set_arm_i) begin
      state_d = ST_ARMED;
      wpnt_d  = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          we = dec_valid_q;
          if (we) wpnt_d = wpnt_q + RSZ'(1);
          if (trig_ev) begin
            trig_d     = 1'b1;
            trig_pnt_d = wpnt_q;
            if (!we) begin
              state_d = ST_TRIGD;
              dly_d   = set_dly_i;
            end else if (set_dly_i == 32'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_TRIGD;
              dly_d   = set_dly_i - 32'd1;
            end
          end
        end
        ST_TRIGD: begin
          we = dec_valid_q;
          if (we) begin
            wpnt_d = wpnt_q + RSZ'(1);
            if (dly_q == 32'd0) state_d = ST_DONE;
            else                dly_d   = dly_q - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and pointer registers.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q    <= ST_IDLE;
      wpnt_q     <= '0;
      trig_pnt_q <= '0;
      dly_q      <= '0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wpnt_q     <= wpnt_d;
      trig_pnt_q <= trig_pnt_d;
      dly_q      <= dly_d;
      trig_q     <= trig_d;
    end
  end

  // Buffer write port; contents are deliberately not reset.
  always_ff @(posedge adc_clk_i) begin
    if (we) buf_mem[wpnt_q] <= dec_dat_q;
  end

  // Registered read port; reads old data when the same address is written.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) rdata_q <= '0;
    else             rdata_q <= buf_mem[buf_addr_i];
  end

  assign buf_rdata_o = rdata_q;
  assign wpnt_o      = wpnt_q;
  assign trig_pnt_o  = trig_pnt_q;
  assign state_o     = state_q;
  assign trig_o      = trig_q;
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_red_pitaya_acq_ch.sv
// Directed bench for red_pitaya_acq_ch with a 16-entry buffer.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same time.
module tb_red_pitaya_acq_ch;

  localparam int RSZ = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [13:0]    adc_dat = '0;
  logic           trig_sw = 1'b0;
  logic           trig_ext = 1'b0;
  logic [2:0]     trig_src = '0;
  logic           set_arm = 1'b0;
  logic           set_rst = 1'b0;
  logic [16:0]    set_dec = 17'd1;
  logic           set_avg_en = 1'b0;
  logic [13:0]    set_tresh = '0;
  logic [13:0]    set_hyst = '0;
  logic [31:0]    set_dly = '0;
  logic [RSZ-1:0] buf_addr = '0;
  logic [13:0]    buf_rdata;
  logic [RSZ-1:0] wpnt;
  logic [RSZ-1:0] trig_pnt;
  logic [1:0]     state;
  logic           trig;
  logic           done;

  int checks = 0;
  int failures = 0;
  int smp = 0;

  red_pitaya_acq_ch #(.RSZ(RSZ)) dut (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .adc_dat_i(adc_dat),
    .trig_sw_i(trig_sw), .trig_ext_i(trig_ext), .trig_src_i(trig_src),
    .set_arm_i(set_arm), .set_rst_i(set_rst), .set_dec_i(set_dec),
    .set_avg_en_i(set_avg_en), .set_tresh_i(set_tresh), .set_hyst_i(set_hyst),
    .set_dly_i(set_dly), .buf_addr_i(buf_addr), .buf_rdata_o(buf_rdata),
    .wpnt_o(wpnt), .trig_pnt_o(trig_pnt), .state_o(state),
    .trig_o(trig), .done_o(done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] dec;
    logic        avg;
    logic        neg;
    int          addr;
    logic [13:0] exp_val;
  } dec_vec_t;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic feed_val(input logic [13:0] v);
    adc_dat = v;
    tick();
  endtask

  // Ramp sample: value equals its index since the last arm.
  task automatic feed();
    adc_dat = 14'(smp);
    smp++;
    tick();
  endtask

  task automatic arm_ramp();
    smp = 0;
    set_arm = 1'b1;
    feed();
    set_arm = 1'b0;
  endtask

  function automatic logic [13:0] pat(input int i, input logic neg);
    int v;
    v = 4 * ((i % 4) + 1);
    if (neg) v = -v;
    return 14'(v);
  endfunction

  task automatic read_chk(input string name, input int a, input logic [13:0] exp_v);
    buf_addr = RSZ'(a);
    tick();
    chk(name, 32'(buf_rdata), 32'(exp_v));
  endtask

  dec_vec_t vecs[11];
  int       early;

  initial begin
    vecs[0]  = '{dec: 17'd4, avg: 1'b1, neg: 1'b0, addr: 1, exp_val: 14'd10};
    vecs[1]  = '{dec: 17'd4, avg: 1'b0, neg: 1'b0, addr: 1, exp_val: 14'd16};
    vecs[2]  = '{dec: 17'd2, avg: 1'b1, neg: 1'b0, addr: 0, exp_val: 14'd6};
    vecs[3]  = '{dec: 17'd2, avg: 1'b1, neg: 1'b0, addr: 1, exp_val: 14'd14};
    vecs[4]  = '{dec: 17'd2, avg: 1'b0, neg: 1'b0, addr: 1, exp_val: 14'd16};
    vecs[5]  = '{dec: 17'd3, avg: 1'b1, neg: 1'b0, addr: 0, exp_val: 14'd12};
    vecs[6]  = '{dec: 17'd3, avg: 1'b1, neg: 1'b0, addr: 1, exp_val: 14'd14};
    vecs[7]  = '{dec: 17'd0, avg: 1'b1, neg: 1'b0, addr: 2, exp_val: 14'd12};
    vecs[8]  = '{dec: 17'd8, avg: 1'b1, neg: 1'b0, addr: 0, exp_val: 14'd10};
    vecs[9]  = '{dec: 17'd4, avg: 1'b1, neg: 1'b1, addr: 0, exp_val: 14'd16374};
    vecs[10] = '{dec: 17'd3, avg: 1'b1, neg: 1'b1, addr: 0, exp_val: 14'd16372};

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wpnt", 32'(wpnt), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_state", 32'(state), 32'd0);

    // Decimation / averaging table
    trig_src = 3'd0;
    for (int v = 0; v < 11; v++) begin
      int d;
      int n;
      d = (vecs[v].dec == 17'd0) ? 1 : int'(vecs[v].dec);
      set_dec = vecs[v].dec;
      set_avg_en = vecs[v].avg;
      set_arm = 1'b1;
      feed_val(pat(0, vecs[v].neg));
      set_arm = 1'b0;
      n = (vecs[v].addr + 1) * d + 1;
      for (int k = 1; k <= n; k++) feed_val(pat(k, vecs[v].neg));
      chk($sformatf("dec_wpnt[%0d]", v), 32'(wpnt), 32'(vecs[v].addr + 1));
      adc_dat = pat(n + 1, vecs[v].neg);
      read_chk($sformatf("dec_data[%0d]", v), vecs[v].addr, vecs[v].exp_val);
    end

    // Software trigger, dly=5, ramp data
    set_dec = 17'd1; set_avg_en = 1'b0; trig_src = 3'd1; set_dly = 32'd5;
    arm_ramp();
    chk("sw_armed", 32'(state), 32'd1);
    repeat (10) feed();
    trig_sw = 1'b1;
    feed();
    trig_sw = 1'b0;
    chk("sw_trig_o", 32'(trig), 32'd1);
    chk("sw_trig_pnt", 32'(trig_pnt), 32'd9);
    chk("sw_state_trigd", 32'(state), 32'd3);
    feed();
    chk("sw_trig_pulse_end", 32'(trig), 32'd0);
    repeat (3) feed();
    chk("sw_not_done_yet", 32'(done), 32'd0);
    feed();
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_state_done", 32'(state), 32'd2);
    chk("sw_wpnt", 32'(wpnt), 32'd15);
    repeat (2) feed();
    chk("sw_wpnt_hold", 32'(wpnt), 32'd15);
    read_chk("sw_rd_first", 9, 14'd9);
    read_chk("sw_rd_last", 14, 14'd14);

    // Software trigger while DONE is ignored
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    chk("done_sw_ignored", 32'(trig), 32'd0);
    chk("done_sw_state", 32'(state), 32'd2);

    // Level trigger, rising
    trig_src = 3'd2; set_tresh = 14'd100; set_hyst = 14'd20; set_dly = 32'd0;
    set_arm = 1'b1;
    feed_val(14'd90);
    set_arm = 1'b0;
    early = 0;
    feed_val(14'd90);  if (trig) early++;
    feed_val(14'd110); if (trig) early++;
    feed_val(14'd110); if (trig) early++;
    feed_val(14'd70);  if (trig) early++;
    feed_val(14'd95);  if (trig) early++;
    feed_val(14'd105); if (trig) early++;
    feed_val(14'd105); if (trig) early++;
    chk("lvl_r_no_early", 32'(early), 32'd0);
    feed_val(14'd105);
    chk("lvl_r_trig", 32'(trig), 32'd1);
    chk("lvl_r_pnt", 32'(trig_pnt), 32'd6);
    chk("lvl_r_done", 32'(state), 32'd2);
    read_chk("lvl_r_data", 6, 14'd105);

    // Level trigger, falling
    trig_src = 3'd3;
    set_arm = 1'b1;
    feed_val(14'd100);
    set_arm = 1'b0;
    feed_val(14'd130);
    feed_val(14'd110);
    feed_val(14'd100);
    feed_val(14'd100);
    chk("lvl_f_no_early", 32'(trig), 32'd0);
    feed_val(14'd100);
    chk("lvl_f_trig", 32'(trig), 32'd1);
    chk("lvl_f_pnt", 32'(trig_pnt), 32'd3);

    // Wrap: 20 samples armed, then dly=40
    trig_src = 3'd1; set_dly = 32'd40;
    arm_ramp();
    repeat (20) feed();
    trig_sw = 1'b1;
    feed();
    trig_sw = 1'b0;
    chk("wrap_trig_pnt", 32'(trig_pnt), 32'd3);
    repeat (39) feed();
    chk("wrap_still_trigd", 32'(state), 32'd3);
    feed();
    chk("wrap_done", 32'(state), 32'd2);
    chk("wrap_wpnt", 32'(wpnt), 32'd12);
    feed();
    read_chk("wrap_last", 11, 14'd59);
    read_chk("wrap_no_extra", 12, 14'd44);

    // set_rst during TRIGD
    set_dly = 32'd20;
    arm_ramp();
    repeat (4) feed();
    trig_sw = 1'b1;
    feed();
    trig_sw = 1'b0;
    chk("abort_trig_pnt", 32'(trig_pnt), 32'd3);
    repeat (2) feed();
    set_rst = 1'b1;
    feed();
    set_rst = 1'b0;
    chk("abort_idle", 32'(state), 32'd0);
    chk("abort_wpnt", 32'(wpnt), 32'd6);
    repeat (4) feed();
    chk("abort_wpnt_hold", 32'(wpnt), 32'd6);

    // set_rst with set_arm, then software trigger in IDLE
    arm_ramp();
    repeat (2) feed();
    set_arm = 1'b1; set_rst = 1'b1;
    feed();
    set_arm = 1'b0; set_rst = 1'b0;
    chk("rst_arm_idle", 32'(state), 32'd0);
    trig_sw = 1'b1;
    feed();
    trig_sw = 1'b0;
    chk("idle_sw_ignored", 32'(trig), 32'd0);
    chk("idle_sw_state", 32'(state), 32'd0);

    // External rising trigger latency, then async reset
    trig_src = 3'd4; set_dly = 32'd3; buf_addr = RSZ'(2);
    arm_ramp();
    repeat (3) feed();
    trig_ext = 1'b1;
    feed();
    chk("ext_lat1", 32'(trig), 32'd0);
    feed();
    chk("ext_lat2", 32'(trig), 32'd0);
    feed();
    chk("ext_lat3", 32'(trig), 32'd1);
    chk("ext_state", 32'(state), 32'd3);
    feed();
    chk("ext_pre_rst_rdata", 32'(buf_rdata), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_wpnt", 32'(wpnt), 32'd0);
    chk("arst_trig_pnt", 32'(trig_pnt), 32'd0);
    chk("arst_done_trig", 32'({done, trig}), 32'd0);
    chk("arst_rdata", 32'(buf_rdata), 32'd0);
    #2;
    rstn = 1'b1;
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
